// File: rtl/sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : sysid_checker
// Brief    : Avalon-MM read master that fetches the system-ID word (addr 0)
//            and build timestamp (addr 1), compares them against build-time
//            constants and publishes match / timeout flags for status logic.
// Revision : 1.0 - initial release
// ============================================================================
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1763369861,
  parameter int unsigned START_DELAY    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err
);

  // Counter widths never drop to zero, even for a zero delay / disabled timeout.
  localparam int unsigned DLY_W = (START_DELAY == 0) ? 1 : $clog2(START_DELAY + 1);
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(START_DELAY);
  // The abort happens on the edge that closes the TIMEOUT_CYCLES-th stalled
  // cycle, i.e. while the counter still holds TIMEOUT_CYCLES-1.
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};
  localparam logic             TMO_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_DELAY = 3'd0,
    S_RD_ID = 3'd1,
    S_RD_TS = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q,  state_d;
  logic [DLY_W-1:0]   dly_q,    dly_d;
  logic [TMO_W-1:0]   tmo_q,    tmo_d;
  logic [31:0]        id_q,     id_d;
  logic [31:0]        ts_q,     ts_d;
  logic               id_ok_q,  id_ok_d;
  logic               ts_ok_q,  ts_ok_d;
  logic               terr_q,   terr_d;

  logic               w_tmo_hit;
  logic [TMO_W-1:0]   w_tmo_inc;

  assign w_tmo_hit = TMO_EN && (tmo_q == TMO_LAST);
  assign w_tmo_inc = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);

  // State and datapath registers; reset discards any read in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_DELAY;
      dly_q   <= '0;
      tmo_q   <= '0;
      id_q    <= '0;
      ts_q    <= '0;
      id_ok_q <= 1'b0;
      ts_ok_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      tmo_q   <= tmo_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      id_ok_q <= id_ok_d;
      ts_ok_q <= ts_ok_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state logic: start delay, two stalled-read captures, compare, idle.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    tmo_d   = tmo_q;
    id_d    = id_q;
    ts_d    = ts_q;
    id_ok_d = id_ok_q;
    ts_ok_d = ts_ok_q;
    terr_d  = terr_q;

    case (state_q)
      S_DELAY: begin
        tmo_d = '0;
        if (dly_q == DLY_LAST) begin
          state_d = S_RD_ID;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end

      S_RD_ID: begin
        if (!waitrequest) begin
          id_d    = readdata;
          tmo_d   = '0;
          state_d = S_RD_TS;
        end else if (w_tmo_hit) begin
          tmo_d   = '0;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          terr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = w_tmo_inc;
        end
      end

      S_RD_TS: begin
        if (!waitrequest) begin
          ts_d    = readdata;
          tmo_d   = '0;
          state_d = S_CHECK;
        end else if (w_tmo_hit) begin
          tmo_d   = '0;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          terr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = w_tmo_inc;
        end
      end

      S_CHECK: begin
        id_ok_d = (id_q == EXPECTED_ID);
        ts_ok_d = (ts_q == EXPECTED_TS);
        terr_d  = 1'b0;
        state_d = S_DONE;
      end

      S_DONE: begin
        tmo_d = '0;
        // A re-run skips the start delay; captured words stay until overwritten.
        if (start) begin
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          state_d = S_RD_ID;
        end
      end

      default: begin
        state_d = S_DELAY;
      end
    endcase
  end

  // Bus strobes and status are pure state decodes, so no input reaches an output.
  assign address     = (state_q == S_RD_TS);
  assign read        = (state_q == S_RD_ID) || (state_q == S_RD_TS);
  assign busy        = (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign id_value    = id_q;
  assign ts_value    = ts_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = terr_q;

endmodule
`default_nettype wire
